// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: shares a bank of external NOR SR latches between two
// requesters, pulses set/reset, then checks the synchronized read-back.
`timescale 1ns/1ps
module sr_latch_ctrl #(
    parameter int N          = 8,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 op0,
    input  logic                 op1,
    input  logic [$clog2(N)-1:0] idx0,
    input  logic [$clog2(N)-1:0] idx1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 err,
    output logic                 busy,
    output logic                 init_done,
    output logic [N-1:0]         latch_set,
    output logic [N-1:0]         latch_reset,
    input  logic [N-1:0]         latch_q
);

    localparam int IW   = $clog2(N);
    localparam int CMAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        INIT_PULSE,
        INIT_SETTLE,
        INIT_CHECK,
        IDLE,
        PULSE,
        SETTLE,
        CHECK
    } state_t;

    state_t          state, nstate;
    logic [CW-1:0]   cnt, ncnt;
    logic [N-1:0]    sync1, sync_q;
    logic            ptr, nptr;
    logic            cur_op, nop;
    logic [IW-1:0]   cur_idx, nidx;
    logic            cur_who, nwho;
    logic [N-1:0]    nset, nrst;
    logic            nack0, nack1, nerr, ninit;
    logic            g0, g1;

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // Two-flop synchronizer for the asynchronous latch outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync_q <= '0;
        end else begin
            sync1  <= latch_q;
            sync_q <= sync1;
        end
    end

    // State, captured command and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT_PULSE;
            cnt         <= '0;
            ptr         <= 1'b0;
            cur_op      <= 1'b0;
            cur_idx     <= '0;
            cur_who     <= 1'b0;
            latch_set   <= '0;
            latch_reset <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            state       <= nstate;
            cnt         <= ncnt;
            ptr         <= nptr;
            cur_op      <= nop;
            cur_idx     <= nidx;
            cur_who     <= nwho;
            latch_set   <= nset;
            latch_reset <= nrst;
            ack0        <= nack0;
            ack1        <= nack1;
            err         <= nerr;
            busy        <= (nstate != IDLE);
            init_done   <= ninit;
        end
    end

    // Round-robin grant: ptr names the requester that wins the next tie.
    always_comb begin
        g0 = req0 & (~req1 | ~ptr);
        g1 = req1 & (~req0 | ptr);
    end

    // Next-state, drive pattern and completion logic.
    always_comb begin
        nstate = state;
        ncnt   = cnt + CW'(1);
        nptr   = ptr;
        nop    = cur_op;
        nidx   = cur_idx;
        nwho   = cur_who;
        nset   = '0;
        nrst   = '0;
        nack0  = 1'b0;
        nack1  = 1'b0;
        nerr   = 1'b0;
        ninit  = init_done;
        unique case (state)
            INIT_PULSE: begin
                if (cnt == CW'(PULSE_CYC)) begin
                    nstate = INIT_SETTLE;
                    ncnt   = '0;
                end else begin
                    nrst = '1;
                end
            end
            INIT_SETTLE: begin
                if (cnt == CW'(SETTLE_CYC - 2)) begin
                    nstate = INIT_CHECK;
                    ncnt   = '0;
                end
            end
            INIT_CHECK: begin
                ninit  = 1'b1;
                nerr   = |sync_q;
                nstate = IDLE;
                ncnt   = '0;
            end
            IDLE: begin
                ncnt = '0;
                if (init_done && (g0 || g1)) begin
                    nstate = PULSE;
                    nwho   = g1;
                    nop    = g1 ? op1 : op0;
                    nidx   = g1 ? idx1 : idx0;
                    nptr   = ~g1;
                    nset   = nop ? onehot(nidx) : '0;
                    nrst   = nop ? '0 : onehot(nidx);
                end
            end
            PULSE: begin
                if (cnt == CW'(PULSE_CYC - 1)) begin
                    nstate = SETTLE;
                    ncnt   = '0;
                end else begin
                    nset = cur_op ? onehot(cur_idx) : '0;
                    nrst = cur_op ? '0 : onehot(cur_idx);
                end
            end
            SETTLE: begin
                if (cnt == CW'(SETTLE_CYC - 2)) begin
                    nstate = CHECK;
                    ncnt   = '0;
                end
            end
            CHECK: begin
                nerr   = (sync_q[cur_idx] != cur_op);
                nack0  = ~cur_who;
                nack1  = cur_who;
                nstate = IDLE;
                ncnt   = '0;
            end
            default: begin
                nstate = INIT_PULSE;
                ncnt   = '0;
            end
        endcase
    end

endmodule
